// File: rtl/if_stage.sv
// Instruction-fetch stage: byte-addressed little-endian fetch into the IF/ID register,
// with branch redirect, stall hold and a sticky halt after four consecutive NOP words.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instruction_mem [255:0],
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned NOP_W   = 3;
  localparam logic [NOP_W-1:0] NOP_LAST = NOP_W'(3);
  localparam logic [DATA_W-1:0] ALIGN_MASK = ~DATA_W'(3);

  logic [BYTE_W-1:0] addr0, addr1, addr2, addr3;
  logic [DATA_W-1:0] fetch_word_c;
  logic [DATA_W-1:0] pc_plus4_c;
  logic [NOP_W-1:0]  nop_count;

  // Byte offsets wrap inside the 256-byte store.
  always_comb begin
    addr0        = pc[BYTE_W-1:0];
    addr1        = addr0 + BYTE_W'(1);
    addr2        = addr0 + BYTE_W'(2);
    addr3        = addr0 + BYTE_W'(3);
    fetch_word_c = {instruction_mem[addr3], instruction_mem[addr2],
                    instruction_mem[addr1], instruction_mem[addr0]};
    pc_plus4_c   = pc + DATA_W'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc                <= '0;
      if_id_instruction <= '0;
      if_id_pc_plus4    <= '0;
      if_id_valid       <= 1'b0;
      halted            <= 1'b0;
      nop_count         <= '0;
    end else if (halted) begin
      if_id_instruction <= '0;
      if_id_valid       <= 1'b0;
    end else if (branch_taken) begin
      pc                <= branch_target & ALIGN_MASK;
      if_id_instruction <= '0;
      if_id_pc_plus4    <= '0;
      if_id_valid       <= 1'b0;
      nop_count         <= '0;
    end else if (!stall) begin
      if_id_instruction <= fetch_word_c;
      if_id_pc_plus4    <= pc_plus4_c;
      if_id_valid       <= 1'b1;
      pc                <= pc_plus4_c;
      if (fetch_word_c == '0) begin
        nop_count <= nop_count + NOP_W'(1);
        // The fourth consecutive NOP is still delivered, then fetch freezes.
        if (nop_count == NOP_LAST) halted <= 1'b1;
      end else begin
        nop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: an abstract fetch model is compared every cycle,
// and hand-computed literals pin the key scenarios.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mem [255:0];
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .instruction_mem(mem), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers and the rules in priority order.
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_halted;
  int          m_zero_run;
  bit          live = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int b;
    b = int'(a % 256);
    return {mem[(b + 3) % 256], mem[(b + 2) % 256], mem[(b + 1) % 256], mem[b]};
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    if (reset) begin
      m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_halted = 0; m_zero_run = 0;
      live = 1;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0;
    end else if (branch_taken) begin
      m_pc = branch_target - (branch_target % 4);
      m_instr = 0; m_p4 = 0; m_valid = 0; m_zero_run = 0;
    end else if (!stall) begin
      w = word_at(m_pc);
      m_instr = w; m_p4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      if (w == 0) begin
        m_zero_run++;
        if (m_zero_run >= 4) m_halted = 1;
      end else m_zero_run = 0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_pc",    pc,                  m_pc);
      chk("model_instr", if_id_instruction,   m_instr);
      chk("model_p4",    if_id_pc_plus4,      m_p4);
      chk("model_valid", 32'(if_id_valid),    32'(m_valid));
      chk("model_halt",  32'(halted),         32'(m_halted));
    end
  end

  // One rising edge, then settle so outputs are stable and inputs may change.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic expect_all(input string name, input logic [31:0] e_pc, input logic [31:0] e_ins,
                            input logic [31:0] e_p4, input logic e_v, input logic e_h);
    chk({name, "_pc"},    pc,                e_pc);
    chk({name, "_instr"}, if_id_instruction, e_ins);
    chk({name, "_p4"},    if_id_pc_plus4,    e_p4);
    chk({name, "_valid"}, 32'(if_id_valid),  32'(e_v));
    chk({name, "_halt"},  32'(halted),       32'(e_h));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'h0a; mem[1] = 8'h00; mem[2] = 8'h0a; mem[3] = 8'h20;
    mem[4] = 8'h0b; mem[5] = 8'h00; mem[6] = 8'h0c; mem[7] = 8'h20;
    mem[252] = 8'h04; mem[253] = 8'h03; mem[254] = 8'h02; mem[255] = 8'h01;
    for (int i = 8'h48; i < 8'h58; i++) mem[i] = 8'h00;

    reset = 1; stall = 0; branch_taken = 1; branch_target = 32'h80;
    tick(); tick();
    expect_all("reset", 0, 0, 0, 0, 0);
    branch_taken = 0;
    reset = 0;

    tick(); expect_all("fetch0", 32'h4, 32'h200a000a, 32'h4, 1, 0);
    tick(); expect_all("fetch4", 32'h8, 32'h200c000b, 32'h8, 1, 0);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_all("stall", 32'h8, 32'h200c000b, 32'h8, 1, 0);
    end
    stall = 0;
    tick(); expect_all("after_stall", 32'hC, 32'h51505352, 32'hC, 1, 0);
    tick(); chk("pc_10", pc, 32'h10);

    branch_taken = 1; stall = 1; branch_target = 32'h000000CB;
    tick(); expect_all("branch_stall", 32'hC8, 0, 0, 0, 0);
    branch_taken = 0; stall = 0;
    tick(); expect_all("fetch_c8", 32'hCC, 32'h91909392, 32'hCC, 1, 0);

    branch_taken = 1; branch_target = 32'hFC;
    tick(); chk("br_fc_pc", pc, 32'hFC);
    branch_taken = 0;
    tick(); expect_all("wrap_fc", 32'h100, 32'h01020304, 32'h100, 1, 0);
    tick(); expect_all("wrap_0", 32'h104, 32'h200a000a, 32'h104, 1, 0);

    branch_taken = 1; branch_target = 32'h40;
    tick(); branch_taken = 0;
    tick(); chk("halt_w40_valid", 32'(if_id_valid), 32'h1);
    tick(); chk("halt_w44_pc", pc, 32'h48);
    tick(); tick(); tick();
    expect_all("three_nops", 32'h54, 0, 32'h54, 1, 0);
    tick(); expect_all("fourth_nop", 32'h58, 0, 32'h58, 1, 1);
    tick(); expect_all("halted_hold", 32'h58, 0, 32'h58, 0, 1);
    branch_taken = 1; branch_target = 32'h10;
    tick(); expect_all("halted_branch", 32'h58, 0, 32'h58, 0, 1);

    reset = 1;
    tick(); expect_all("mid_reset", 0, 0, 0, 0, 0);
    reset = 0; branch_taken = 0;
    tick(); expect_all("post_reset", 32'h4, 32'h200a000a, 32'h4, 1, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
